// File: rtl/tl_countdown_disp.sv
// Countdown display for the two-way traffic-light controller: per-direction seconds-remaining
// counters driving a 4-digit multiplexed common-anode 7-segment display. Optional blink: TL_CD_FLASH_EN.
module tl_countdown_disp #(
  parameter int G_TIME   = 40,
  parameter int Y_TIME   = 5,
  parameter int R_TIME   = 45,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       R1,
  input  logic       Y1,
  input  logic       G1,
  input  logic       R2,
  input  logic       Y2,
  input  logic       G2,
  output logic [5:0] rem1,
  output logic [5:0] rem2,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Phase length for a one-hot {R,Y,G} code; any other code loads 0.
  function automatic logic [5:0] phase_len(input logic [2:0] code);
    case (code)
      3'b100:  return 6'(R_TIME);
      3'b010:  return 6'(Y_TIME);
      3'b001:  return 6'(G_TIME);
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] sat_dec(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction

  // Binary 0..63 to {tens, ones} by compare/subtract, no divider.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if      (v >= 6'd60) begin t = 4'd6; r = v - 6'd60; end
    else if (v >= 6'd50) begin t = 4'd5; r = v - 6'd50; end
    else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
    else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
    else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
    else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
    else                 begin t = 4'd0; r = v;          end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [2:0]        code1, code2;
  logic [2:0]        prev1_p0, prev2_p0;
  logic [5:0]        rem1_p0, rem2_p0;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [3:0]        an_p1;
  logic [6:0]        seg_p1;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic [5:0]        sel_rem;
  logic [2:0]        sel_code;
  logic [7:0]        sel_bcd;
  logic              blank_now;

  assign code1 = {R1, Y1, G1};
  assign code2 = {R2, Y2, G2};

  // Stage p0: lamp sampling and countdown; a phase change wins over a same-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev1_p0 <= 3'b000;
      prev2_p0 <= 3'b000;
      rem1_p0  <= 6'd0;
      rem2_p0  <= 6'd0;
    end else begin
      if (code1 != prev1_p0) begin
        prev1_p0 <= code1;
        rem1_p0  <= phase_len(code1);
      end else if (tick) begin
        rem1_p0  <= sat_dec(rem1_p0);
      end
      if (code2 != prev2_p0) begin
        prev2_p0 <= code2;
        rem2_p0  <= phase_len(code2);
      end else if (tick) begin
        rem2_p0  <= sat_dec(rem2_p0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef TL_CD_FLASH_EN
  logic blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     blink <= 1'b0;
    else if (tick) blink <= ~blink;
  end

  assign blank_now = blink && (sel_rem >= 6'd1) && (sel_rem <= 6'd3);
`else
  assign blank_now = 1'b0;
`endif

  // idx[1] picks the direction, idx[0] picks tens over ones.
  always_comb begin
    sel_rem  = idx[1] ? rem2_p0  : rem1_p0;
    sel_code = idx[1] ? prev2_p0 : prev1_p0;
    sel_bcd  = bcd_split(sel_rem);
    an_nxt   = ~(4'b0001 << idx);
    seg_nxt  = SEG_BLANK;
    if (!$onehot(sel_code))   seg_nxt = SEG_DASH;
    else if (blank_now)       seg_nxt = SEG_BLANK;
    else if (idx[0]) begin
      if (sel_bcd[7:4] != 4'd0) seg_nxt = glyph(sel_bcd[7:4]);
    end else                  seg_nxt = glyph(sel_bcd[3:0]);
  end

  // Stage p1: registered digit enable and segment drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p1  <= 4'b1111;
      seg_p1 <= SEG_BLANK;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
    end
  end

  assign rem1 = rem1_p0;
  assign rem2 = rem2_p0;
  assign an   = an_p1;
  assign seg  = seg_p1;

endmodule
